// File: rtl/pic_ctl.sv
// pic_ctl - programmable interrupt controller for the 16-bit core.
//
// Latches rising edges on up to eight request lines, masks them, picks one by
// fixed or rotating priority and hands its vector to the core with a toggle
// handshake on irq. Software talks to it through three I/O ports.
//
// Ports:
//   clock    in   system clock, all registers update on its rising edge
//   reset_n  in   synchronous active-low reset
//   req      in   IRQ_COUNT request lines (synchronous to clock)
//   port_a   in   16-bit I/O port address
//   port_w   in   one-cycle port write strobe
//   port_r   in   one-cycle port read strobe
//   port_o   in   8-bit port write data
//   port_i   out  8-bit registered port read data
//   irq      out  toggles once per dispatched interrupt
//   irq_in   out  vector number, stable between toggles
module pic_ctl #(
   parameter int          IRQ_COUNT = 8,
   parameter logic [7:0]  VEC_BASE  = 8'h08,
   parameter logic [15:0] PORT_BASE = 16'h0020
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [IRQ_COUNT-1:0] req,
   input  logic [15:0]          port_a,
   input  logic                 port_w,
   input  logic                 port_r,
   input  logic [7:0]           port_o,
   output logic [7:0]           port_i,
   output logic                 irq,
   output logic [7:0]           irq_in
);

   // Bits at IRQ_COUNT and above are never allowed to hold a 1.
   localparam logic [7:0] VALID_M = 8'((9'd1 << IRQ_COUNT) - 9'd1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t               state_q;
   logic [7:0]           irr_q, irr_d;
   logic [7:0]           imr_q;
   logic [7:0]           isr_q;
   logic [IRQ_COUNT-1:0] prev_q;
   logic [7:0]           vbase_q;
   logic                 rot_q;
   logic [2:0]           lowp_q;
   logic [2:0]           cur_q;      // line dispatched most recently
   logic                 irq_q;
   logic [7:0]           irq_in_q;
   logic [7:0]           port_i_q;

   logic [7:0] edge_w;
   logic [7:0] pend_w;
   logic       sel_vld_w;
   logic [2:0] sel_k_w;
   logic       dispatch_w;
   int         start_w;
   int         idx_w;

   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

   assign edge_w = 8'(req & ~prev_q);

   // Scan from the lowest-priority end back to the highest so the last hit
   // wins; start_w is the highest-priority index.
   always_comb begin
      pend_w    = irr_q & ~imr_q;
      sel_vld_w = 1'b0;
      sel_k_w   = 3'd0;
      idx_w     = 0;
      start_w   = 0;
      if (rot_q) begin
         start_w = int'(lowp_q) + 1;
         if (start_w >= IRQ_COUNT) start_w = 0;
      end
      for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
         idx_w = start_w + i;
         if (idx_w >= IRQ_COUNT) idx_w = idx_w - IRQ_COUNT;
         if (pend_w[idx_w[2:0]]) begin
            sel_vld_w = 1'b1;
            sel_k_w   = idx_w[2:0];
         end
      end
   end

   assign dispatch_w = (state_q == S_IDLE) && sel_vld_w;

   // A new edge on the line being cleared by dispatch keeps the bit set.
   always_comb begin
      irr_d = irr_q;
      if (dispatch_w) irr_d = irr_d & ~(8'd1 << sel_k_w);
      irr_d = irr_d | edge_w;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         irr_q    <= 8'd0;
         imr_q    <= 8'd0;
         isr_q    <= 8'd0;
         prev_q   <= '0;
         vbase_q  <= VEC_BASE;
         rot_q    <= 1'b0;
         lowp_q   <= 3'(IRQ_COUNT - 1);
         cur_q    <= 3'd0;
         irq_q    <= 1'b0;
         irq_in_q <= 8'd0;
         port_i_q <= 8'd0;
      end else begin
         prev_q <= req;
         irr_q  <= irr_d;

         if (dispatch_w) begin
            isr_q    <= 8'd1 << sel_k_w;
            cur_q    <= sel_k_w;
            irq_in_q <= vbase_q + {5'd0, sel_k_w};
            irq_q    <= ~irq_q;
            state_q  <= S_BUSY;
         end

         if (port_w && port_a == PORT_BASE) begin
            // EOI only means something while a line is in service.
            if (port_o[5] && state_q == S_BUSY) begin
               isr_q <= 8'd0;
               if (rot_q) lowp_q <= onehot_idx(isr_q);
               state_q <= S_IDLE;
            end
            if (port_o[7]) rot_q <= port_o[0];
         end
         if (port_w && port_a == PORT_BASE + 16'd1) imr_q   <= port_o & VALID_M;
         if (port_w && port_a == PORT_BASE + 16'd2) vbase_q <= port_o;

         if (port_r) begin
            if (port_a == PORT_BASE)
               port_i_q <= irr_q;
            else if (port_a == PORT_BASE + 16'd1)
               port_i_q <= imr_q;
            else if (port_a == PORT_BASE + 16'd2)
               port_i_q <= {rot_q, (state_q == S_BUSY), 3'b000, cur_q};
         end
      end
   end

   assign port_i = port_i_q;
   assign irq    = irq_q;
   assign irq_in = irq_in_q;

endmodule

// File: tb/tb_pic_ctl.sv
// tb_pic_ctl - self-checking bench for pic_ctl (IRQ_COUNT = 8, default ports).
//
// A vector table covers first-dispatch vectors for several bases and request
// patterns, hand-written sequences cover the multi-cycle corner cases, and a
// randomized section is checked against a transaction-level priority model.
module tb_pic_ctl;

   logic        clock;
   logic        reset_n;
   logic [7:0]  req;
   logic [15:0] port_a;
   logic        port_w;
   logic        port_r;
   logic [7:0]  port_o;
   logic [7:0]  port_i;
   logic        irq;
   logic [7:0]  irq_in;

   int   n_cmp;
   int   n_bad;
   logic irq_exp;

   pic_ctl #(.IRQ_COUNT(8), .VEC_BASE(8'h08), .PORT_BASE(16'h0020)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .req    (req),
      .port_a (port_a),
      .port_w (port_w),
      .port_r (port_r),
      .port_o (port_o),
      .port_i (port_i),
      .irq    (irq),
      .irq_in (irq_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] vb;
      logic [7:0] rq;
      logic [7:0] exp_vec;
   } vec_t;

   vec_t tbl[6];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      port_a = a;
      port_o = d;
      port_w = 1'b1;
      tick();
      port_w = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] v);
      port_a = a;
      port_r = 1'b1;
      tick();
      port_r = 1'b0;
      v = port_i;
   endtask

   task automatic pulse(input logic [7:0] bits);
      req = bits;
      tick();
      req = 8'd0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      irq_exp = 1'b0;
   endtask

   task automatic wait_toggle(input string nm, input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         tick();
         if (irq !== irq_exp) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s: irq stayed %0b for %0d cycles, expected a toggle", nm, irq_exp, budget);
      end else begin
         irq_exp = ~irq_exp;
      end
   endtask

   task automatic quiet(input string nm, input int cycles);
      bit moved;
      moved = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (irq !== irq_exp) moved = 1'b1;
      end
      n_cmp++;
      if (moved) begin
         n_bad++;
         $display("FAIL %s: irq toggled to %0b, expected no toggle", nm, irq);
         irq_exp = irq;
      end
   endtask

   // Highest-priority pending index from the priority rules, -1 if none.
   function automatic int pick(input logic [7:0] p, input bit r, input int lp);
      for (int i = 0; i < 8; i++) begin
         int idx;
         idx = r ? (lp + 1 + i) % 8 : i;
         if (p[idx]) return idx;
      end
      return -1;
   endfunction

   initial begin
      logic [7:0] v;
      logic [7:0] v2;

      tbl[0] = '{vb: 8'h70, rq: 8'h80, exp_vec: 8'h77};
      tbl[1] = '{vb: 8'hFC, rq: 8'h80, exp_vec: 8'h03};
      tbl[2] = '{vb: 8'h08, rq: 8'h0A, exp_vec: 8'h09};
      tbl[3] = '{vb: 8'h00, rq: 8'hFF, exp_vec: 8'h00};
      tbl[4] = '{vb: 8'h10, rq: 8'hF0, exp_vec: 8'h14};
      tbl[5] = '{vb: 8'hFF, rq: 8'h06, exp_vec: 8'h00};

      n_cmp   = 0;
      n_bad   = 0;
      irq_exp = 1'b0;
      reset_n = 1'b0;
      req     = 8'd0;
      port_a  = 16'd0;
      port_w  = 1'b0;
      port_r  = 1'b0;
      port_o  = 8'd0;
      tick();
      tick();
      reset_n = 1'b1;

      // Reset state
      check8("rst_irq", {7'd0, irq}, 8'h00);
      check8("rst_irq_in", irq_in, 8'h00);
      check8("rst_port_i", port_i, 8'h00);
      rd(16'h0020, v); check8("rst_irr", v, 8'h00);
      rd(16'h0021, v); check8("rst_imr", v, 8'h00);
      rd(16'h0022, v); check8("rst_stat", v, 8'h00);

      // Table: first dispatch vector for a given base and request pattern
      for (int t = 0; t < 6; t++) begin
         do_reset();
         wr(16'h0022, tbl[t].vb);
         pulse(tbl[t].rq);
         wait_toggle($sformatf("tbl%0d_toggle", t), 10);
         check8($sformatf("tbl%0d_vec", t), irq_in, tbl[t].exp_vec);
      end

      // Fixed priority with exact latency
      do_reset();
      pulse(8'h0A);
      check8("lat_n1", {7'd0, irq}, {7'd0, irq_exp});
      tick();
      check8("lat_n2", {7'd0, irq}, {7'd0, ~irq_exp});
      irq_exp = ~irq_exp;
      check8("fix_vec1", irq_in, 8'h09);
      rd(16'h0022, v); check8("fix_stat_busy", v, 8'h41);
      wr(16'h0020, 8'h20);
      check8("eoi_no_same_edge", {7'd0, irq}, {7'd0, irq_exp});
      tick();
      check8("eoi_next_toggle", {7'd0, irq}, {7'd0, ~irq_exp});
      irq_exp = ~irq_exp;
      check8("fix_vec2", irq_in, 8'h0B);
      wr(16'h0020, 8'h20);

      // Masking
      wr(16'h0021, 8'h02);
      pulse(8'h02);
      quiet("mask_hold", 100);
      rd(16'h0020, v); check8("mask_irr", v, 8'h02);
      rd(16'h0030, v2); check8("other_addr_keeps", v2, v);
      wr(16'h0021, 8'h00);
      wait_toggle("unmask_toggle", 10);
      check8("unmask_vec", irq_in, 8'h09);

      // Busy hold: a new edge waits for EOI
      pulse(8'h04);
      quiet("busy_hold", 20);
      rd(16'h0020, v); check8("busy_irr", v, 8'h04);
      wr(16'h0020, 8'h20);
      wait_toggle("busy_release", 10);
      check8("busy_vec", irq_in, 8'h0A);
      wr(16'h0020, 8'h20);

      // EOI in IDLE is ignored
      wr(16'h0020, 8'h20);
      quiet("eoi_idle_quiet", 5);
      rd(16'h0022, v); check8("eoi_idle_stat", v, 8'h02);

      // New edge on a line in the same cycle it is dispatched
      wr(16'h0021, 8'h10);
      pulse(8'h10);
      quiet("same_mask", 3);
      wr(16'h0021, 8'h00);
      req = 8'h10;
      tick();
      req = 8'h00;
      check8("same_toggle", {7'd0, irq}, {7'd0, ~irq_exp});
      irq_exp = ~irq_exp;
      check8("same_vec", irq_in, 8'h0C);
      rd(16'h0020, v); check8("same_irr_kept", v, 8'h10);
      wr(16'h0020, 8'h20);
      wait_toggle("same_second", 10);
      check8("same_vec2", irq_in, 8'h0C);
      wr(16'h0020, 8'h20);

      // Rotating priority
      do_reset();
      wr(16'h0020, 8'h81);
      pulse(8'h01);
      wait_toggle("rot_first", 10);
      check8("rot_vec0", irq_in, 8'h08);
      wr(16'h0020, 8'h20);
      pulse(8'h21);
      wait_toggle("rot_a", 10);
      check8("rot_vec5", irq_in, 8'h0D);
      wr(16'h0020, 8'h20);
      wait_toggle("rot_b", 10);
      check8("rot_vec0b", irq_in, 8'h08);
      wr(16'h0020, 8'h20);
      rd(16'h0022, v); check8("rot_stat", v, 8'h80);

      // Reset in the middle of operation
      pulse(8'h01);
      wait_toggle("mid_first", 10);
      pulse(8'h30);
      tick();
      rd(16'h0020, v); check8("mid_irr", v, 8'h30);
      do_reset();
      check8("mid_irq", {7'd0, irq}, 8'h00);
      check8("mid_irq_in", irq_in, 8'h00);
      check8("mid_port_i", port_i, 8'h00);
      quiet("mid_quiet", 20);
      rd(16'h0020, v); check8("mid_irr_rst", v, 8'h00);
      rd(16'h0022, v); check8("mid_stat_rst", v, 8'h00);
      pulse(8'h81);
      wait_toggle("mid_fixed_again", 10);
      check8("mid_vec", irq_in, 8'h08);

      // Randomized transactions against the priority model
      do_reset();
      begin
         bit         m_rot;
         int         m_lowp;
         logic [7:0] vb, msk, pend;
         int         k;
         m_rot  = 1'b0;
         m_lowp = 7;
         for (int it = 0; it < 40; it++) begin
            vb    = 8'($urandom_range(0, 255));
            msk   = 8'($urandom_range(0, 255));
            m_rot = 1'($urandom_range(0, 1));
            wr(16'h0022, vb);
            wr(16'h0020, {7'b1000000, m_rot});
            wr(16'h0021, msk);
            pend = 8'($urandom_range(1, 255));
            pulse(pend);
            for (int pass = 0; pass < 2; pass++) begin
               k = pick(pend & ~msk, m_rot, m_lowp);
               while (k >= 0) begin
                  wait_toggle($sformatf("rnd%0d_toggle", it), 10);
                  check8($sformatf("rnd%0d_vec", it), irq_in, vb + 8'(k));
                  pend[k] = 1'b0;
                  wr(16'h0020, 8'h20);
                  if (m_rot) m_lowp = k;
                  k = pick(pend & ~msk, m_rot, m_lowp);
               end
               if (pass == 0) begin
                  quiet($sformatf("rnd%0d_quiet", it), 4);
                  rd(16'h0020, v); check8($sformatf("rnd%0d_irr", it), v, pend);
                  rd(16'h0021, v); check8($sformatf("rnd%0d_imr", it), v, msk);
                  msk = 8'h00;
                  wr(16'h0021, msk);
               end
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
